// File: rtl/calc_pkg.sv
// Shared widths, key codes, operator encodings and FSM states for the calculator controller.
package calc_pkg;

  localparam int unsigned WIDTH      = 28;
  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned TIMEOUT    = 255;
  localparam int unsigned MAG_W      = 27;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned WAIT_W     = 8;
  localparam int unsigned KEY_W      = 4;

  localparam logic [KEY_W-1:0] KEY_ADD = 4'd10;
  localparam logic [KEY_W-1:0] KEY_SUB = 4'd11;
  localparam logic [KEY_W-1:0] KEY_MUL = 4'd12;
  localparam logic [KEY_W-1:0] KEY_DIV = 4'd13;
  localparam logic [KEY_W-1:0] KEY_EQ  = 4'd14;
  localparam logic [KEY_W-1:0] KEY_CLR = 4'd15;

  typedef enum logic [1:0] {
    OP_SUMA = 2'd0,
    OP_DIF  = 2'd1,
    OP_PROD = 2'd2,
    OP_IMP  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_A     = 3'd0,
    S_B     = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_SHOW  = 3'd4
  } state_e;

  function automatic logic key_is_digit(input logic [KEY_W-1:0] k);
    return k < 4'd10;
  endfunction

  function automatic logic key_is_op(input logic [KEY_W-1:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

  // Operator keys are contiguous, so the encoding is the offset from '+'.
  function automatic op_e key_to_op(input logic [KEY_W-1:0] k);
    return op_e'(2'(k - KEY_ADD));
  endfunction

endpackage

// File: rtl/calc_if.sv
// Issue/response bus between the controller and the muxed arithmetic operators.
interface calc_if;
  import calc_pkg::*;

  logic signed [WIDTH-1:0] n1;
  logic signed [WIDTH-1:0] n2;
  logic                    valid_in;
  logic [1:0]              op_sel;
  logic                    res_valid;
  logic                    res_err;
  logic signed [WIDTH-1:0] res_data;

  modport master (
    output n1, n2, valid_in, op_sel,
    input  res_valid, res_err, res_data
  );

  modport slave (
    input  n1, n2, valid_in, op_sel,
    output res_valid, res_err, res_data
  );

endinterface

// File: rtl/calc_dec_accum.sv
// Decimal entry accumulator: digit count, x10+d magnitude, sign flag and clear.
module calc_dec_accum
  import calc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    dig_en,
  input  logic [KEY_W-1:0]        dig,
  input  logic                    neg_en,
  output logic [MAG_W-1:0]        mag,
  output logic                    neg,
  output logic [CNT_W-1:0]        cnt,
  output logic signed [WIDTH-1:0] value_c
);

  logic [MAG_W-1:0]        mag_q, mag_d;
  logic                    neg_q, neg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [WIDTH-1:0] mag_ext;

  // Clear first so a clear+digit in one cycle starts a fresh operand with that digit.
  always_comb begin
    mag_d = mag_q;
    neg_d = neg_q;
    cnt_d = cnt_q;
    if (clr) begin
      mag_d = '0;
      neg_d = 1'b0;
      cnt_d = '0;
    end
    if (dig_en && (cnt_d < CNT_W'(MAX_DIGITS))) begin
      mag_d = MAG_W'(mag_d * MAG_W'(10)) + MAG_W'(dig);
      cnt_d = cnt_d + CNT_W'(1);
    end
    if (neg_en) begin
      neg_d = 1'b1;
    end
  end

  // Entry state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q <= '0;
      neg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      mag_q <= mag_d;
      neg_q <= neg_d;
      cnt_q <= cnt_d;
    end
  end

  assign mag     = mag_q;
  assign neg     = neg_q;
  assign cnt     = cnt_q;
  assign mag_ext = WIDTH'(mag_q);
  // Magnitude is at most 99_999_999, so negation in WIDTH bits cannot overflow.
  assign value_c = neg_q ? -mag_ext : mag_ext;

endmodule

// File: rtl/calc_ctrl.sv
// Keypad-to-operator sequencer: builds operands, issues them, captures the operator result.
module calc_ctrl
  import calc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [KEY_W-1:0]        key_code,
  calc_if.master                  bus,
  output logic [MAG_W-1:0]        entry_mag,
  output logic                    entry_neg,
  output logic signed [WIDTH-1:0] result,
  output logic                    result_err,
  output logic                    result_valid,
  output logic                    busy
);

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] n1_q, n1_d;
  logic signed [WIDTH-1:0] n2_q, n2_d;
  logic signed [WIDTH-1:0] result_q, result_d;
  op_e                     op_q, op_d;
  logic                    valid_in_q, valid_in_d;
  logic                    result_err_q, result_err_d;
  logic                    result_valid_q, result_valid_d;
  logic                    busy_q, busy_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;

  logic                    acc_clr, acc_dig_en, acc_neg_en;
  logic [MAG_W-1:0]        acc_mag;
  logic                    acc_neg;
  logic [CNT_W-1:0]        acc_cnt;
  logic signed [WIDTH-1:0] acc_value_c;

  logic is_digit, is_op, is_eq, is_clr, entry_empty, sign_key;

  calc_dec_accum u_accum (
    .clk     (clk),
    .rst     (rst),
    .clr     (acc_clr),
    .dig_en  (acc_dig_en),
    .dig     (key_code),
    .neg_en  (acc_neg_en),
    .mag     (acc_mag),
    .neg     (acc_neg),
    .cnt     (acc_cnt),
    .value_c (acc_value_c)
  );

  assign is_digit    = key_is_digit(key_code);
  assign is_op       = key_is_op(key_code);
  assign is_eq       = (key_code == KEY_EQ);
  assign is_clr      = (key_code == KEY_CLR);
  assign entry_empty = (acc_cnt == '0) && !acc_neg;
  // A leading '-' on an empty, positive entry is a sign, not the SUB operator.
  assign sign_key    = (key_code == KEY_SUB) && entry_empty;

  // Next-state, operand latch, wait counter and result capture.
  always_comb begin
    state_d        = state_q;
    n1_d           = n1_q;
    n2_d           = n2_q;
    op_d           = op_q;
    result_d       = result_q;
    result_err_d   = result_err_q;
    valid_in_d     = 1'b0;
    result_valid_d = 1'b0;
    wait_d         = wait_q;
    acc_clr        = 1'b0;
    acc_dig_en     = 1'b0;
    acc_neg_en     = 1'b0;

    unique case (state_q)
      S_A: begin
        if (key_valid) begin
          if (is_clr) begin
            acc_clr = 1'b1;
          end else if (is_digit) begin
            acc_dig_en = 1'b1;
          end else if (sign_key) begin
            acc_neg_en = 1'b1;
          end else if (is_op) begin
            op_d    = key_to_op(key_code);
            n1_d    = acc_value_c;
            acc_clr = 1'b1;
            state_d = S_B;
          end
        end
      end
      S_B: begin
        if (key_valid) begin
          if (is_clr) begin
            acc_clr = 1'b1;
            state_d = S_A;
          end else if (is_digit) begin
            acc_dig_en = 1'b1;
          end else if (sign_key) begin
            acc_neg_en = 1'b1;
          end else if (is_op) begin
            if (entry_empty) begin
              op_d = key_to_op(key_code);
            end
          end else if (is_eq) begin
            n2_d       = acc_value_c;
            acc_clr    = 1'b1;
            valid_in_d = 1'b1;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (key_valid && is_clr) begin
          acc_clr = 1'b1;
          state_d = S_A;
        end else if (bus.res_valid) begin
          result_d       = bus.res_data;
          result_err_d   = bus.res_err;
          result_valid_d = 1'b1;
          state_d        = S_SHOW;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          result_d       = '0;
          result_err_d   = 1'b1;
          result_valid_d = 1'b1;
          state_d        = S_SHOW;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_SHOW: begin
        if (key_valid) begin
          if (is_clr) begin
            acc_clr = 1'b1;
            state_d = S_A;
          end else if (is_digit) begin
            acc_clr    = 1'b1;
            acc_dig_en = 1'b1;
            state_d    = S_A;
          end else if (is_op && !result_err_q) begin
            n1_d    = result_q;
            op_d    = key_to_op(key_code);
            state_d = S_B;
          end
        end
      end
      default: begin
        state_d = S_A;
      end
    endcase

    busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_A;
      n1_q           <= '0;
      n2_q           <= '0;
      op_q           <= OP_SUMA;
      result_q       <= '0;
      result_err_q   <= 1'b0;
      valid_in_q     <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      wait_q         <= '0;
    end else begin
      state_q        <= state_d;
      n1_q           <= n1_d;
      n2_q           <= n2_d;
      op_q           <= op_d;
      result_q       <= result_d;
      result_err_q   <= result_err_d;
      valid_in_q     <= valid_in_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      wait_q         <= wait_d;
    end
  end

  assign bus.n1       = n1_q;
  assign bus.n2       = n2_q;
  assign bus.op_sel   = op_q;
  assign bus.valid_in = valid_in_q;
  assign entry_mag    = acc_mag;
  assign entry_neg    = acc_neg;
  assign result       = result_q;
  assign result_err   = result_err_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Scoreboard bench for calc_ctrl with a behavioural calculator model and an operator stub.
module tb_calc_ctrl;
  import calc_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    key_valid = 1'b0;
  logic [KEY_W-1:0]        key_code = '0;
  logic [MAG_W-1:0]        entry_mag;
  logic                    entry_neg;
  logic signed [WIDTH-1:0] result;
  logic                    result_err;
  logic                    result_valid;
  logic                    busy;

  calc_if bus();

  calc_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .bus          (bus),
    .entry_mag    (entry_mag),
    .entry_neg    (entry_neg),
    .result       (result),
    .result_err   (result_err),
    .result_valid (result_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct { longint a; longint b; int op; } iss_t;
  typedef struct { longint r; bit e; int lat; } res_t;

  iss_t iss_q[$];
  res_t res_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   rv_count = 0;
  int   wcyc = 0;
  int   resp_mode = 0;   // 0 answer, 1 never answer, 2 answer very late
  bit   just_eq = 0;
  bit   last_issued = 0;

  // Calculator model state
  int     m_phase;       // 0 typing first operand, 1 typing second, 2 computing, 3 showing
  longint m_mag;
  int     m_cnt;
  bit     m_neg;
  longint m_a, m_b, m_res;
  int     m_op;
  bit     m_rerr;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event not as required", name);
  endtask

  function automatic void calc(input longint a, input longint b, input int op,
                               output longint r, output bit e);
    e = 1'b0;
    r = 0;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a * b;
      default: begin
        if (b == 0) e = 1'b1;
        else r = a / b;
      end
    endcase
    if (r > 134217727 || r < -134217728) begin
      r = 0;
      e = 1'b1;
    end
  endfunction

  function automatic void ent_clear();
    m_mag = 0;
    m_cnt = 0;
    m_neg = 1'b0;
  endfunction

  function automatic longint ent_val();
    return m_neg ? -m_mag : m_mag;
  endfunction

  function automatic void model_reset();
    ent_clear();
    m_phase = 0;
    m_a = 0; m_b = 0; m_res = 0; m_op = 0; m_rerr = 1'b0;
  endfunction

  // Applies one key to the model; returns 1 when the key launches an operation.
  function automatic bit model_key(input int k, input bit in_issue);
    iss_t   ie;
    res_t   re;
    longint r;
    bit     e;
    if (m_phase == 2) begin
      if (k == 15 && !in_issue) begin
        ent_clear();
        m_phase = 0;
      end
      return 1'b0;
    end
    if (k == 15) begin
      ent_clear();
      m_phase = 0;
      return 1'b0;
    end
    if (k < 10) begin
      if (m_phase == 3) begin
        ent_clear();
        m_phase = 0;
      end
      if (m_cnt < 8) begin
        m_mag = m_mag * 10 + k;
        m_cnt++;
      end
      return 1'b0;
    end
    if (k == 11 && m_phase < 2 && m_cnt == 0 && !m_neg) begin
      m_neg = 1'b1;
      return 1'b0;
    end
    if (k >= 10 && k <= 13) begin
      if (m_phase == 0) begin
        m_a = ent_val();
        m_op = k - 10;
        ent_clear();
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (m_cnt == 0 && !m_neg) m_op = k - 10;
      end else if (!m_rerr) begin
        m_a = m_res;
        m_op = k - 10;
        m_phase = 1;
      end
      return 1'b0;
    end
    if (k == 14 && m_phase == 1) begin
      m_b = ent_val();
      ent_clear();
      m_phase = 2;
      ie.a = m_a; ie.b = m_b; ie.op = m_op;
      iss_q.push_back(ie);
      calc(m_a, m_b, m_op, r, e);
      if (resp_mode == 0) begin
        re.r = r; re.e = e; re.lat = -1;
        res_q.push_back(re);
        m_res = r; m_rerr = e;
      end else if (resp_mode == 1) begin
        re.r = 0; re.e = 1'b1; re.lat = TIMEOUT;
        res_q.push_back(re);
        m_res = 0; m_rerr = 1'b1;
      end
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic press(input int k);
    bit iss;
    iss = just_eq;
    key_valid = 1'b1;
    key_code  = KEY_W'(k);
    last_issued = model_key(k, iss);
    just_eq = last_issued;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
    just_eq = 1'b0;
  endtask

  task automatic wait_result();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (result_valid) got = 1'b1;
    end
    if (!got) fail("result_wait_timeout");
    @(posedge clk); #1;
    just_eq = 1'b0;
    if (m_phase == 2) m_phase = 3;
  endtask

  task automatic press_seq(input int ks[]);
    foreach (ks[i]) press(ks[i]);
  endtask

  // Monitor: pops expected issues/results whenever the DUT presents them.
  initial begin
    iss_t ie;
    res_t re;
    logic prev_vi, prev_rv;
    prev_vi = 1'b0;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.valid_in) begin
          check("valid_in_width", longint'(prev_vi), 0);
          if (iss_q.size() == 0) fail("unexpected_issue");
          else begin
            ie = iss_q.pop_front();
            check("n1", longint'(bus.n1), ie.a);
            check("n2", longint'(bus.n2), ie.b);
            check("op_sel", longint'(bus.op_sel), longint'(ie.op));
          end
          wcyc = 0;
        end else if (busy) begin
          wcyc++;
        end
        if (result_valid) begin
          rv_count++;
          check("result_valid_width", longint'(prev_rv), 0);
          check("busy_at_result", longint'(busy), 0);
          if (res_q.size() == 0) fail("unexpected_result");
          else begin
            re = res_q.pop_front();
            check("result", longint'(result), re.r);
            check("result_err", longint'(result_err), longint'(re.e));
            if (re.lat >= 0) check("timeout_wait_cycles", longint'(wcyc), longint'(re.lat));
          end
        end
      end
      prev_vi = bus.valid_in;
      prev_rv = result_valid;
    end
  end

  // Operator stub: answers each issue after a random latency.
  initial begin
    longint a, b, r;
    int     op, lat;
    bit     e;
    bus.res_valid = 1'b0;
    bus.res_err   = 1'b0;
    bus.res_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.valid_in && resp_mode != 1) begin
        a  = longint'(bus.n1);
        b  = longint'(bus.n2);
        op = int'(bus.op_sel);
        calc(a, b, op, r, e);
        lat = (resp_mode == 2) ? 30 : int'($urandom_range(1, 6));
        repeat (lat) @(posedge clk);
        #1;
        bus.res_valid = 1'b1;
        bus.res_err   = e;
        bus.res_data  = WIDTH'(r);
        @(posedge clk); #1;
        bus.res_valid = 1'b0;
        bus.res_err   = 1'b0;
        bus.res_data  = '0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv0, k, r;
    model_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_entry_mag", longint'(entry_mag), 0);
    check("rst_result", longint'(result), 0);
    check("rst_valid_in", longint'(bus.valid_in), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_op_sel", longint'(bus.op_sel), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // 412 + 3534
    resp_mode = 0;
    press_seq('{4, 1, 2, 10, 3, 5, 3, 4, 14});
    wait_result();
    check("t1_result", longint'(result), 3946);

    // -2556 / 0
    press_seq('{15, 11, 2, 5, 5, 6, 13, 0, 14});
    wait_result();
    check("t2_result_err", longint'(result_err), 1);

    // 9th digit ignored, then SUB with a negative second operand
    press_seq('{15, 1, 2, 3, 4, 5, 6, 7, 8, 9});
    check("t3_entry_mag", longint'(entry_mag), 12345678);
    press_seq('{11, 11, 5});
    check("t3_entry_neg", longint'(entry_neg), 1);
    press(14);
    wait_result();

    // operator never answers
    resp_mode = 1;
    press_seq('{15, 7, 10, 8, 14});
    wait_result();
    check("t4_busy_after", longint'(busy), 0);
    resp_mode = 0;

    // 169 / 13 then chain * 2 with a key during issue
    press_seq('{15, 1, 6, 9, 13, 1, 3, 14});
    wait_result();
    check("t5_first", longint'(result), 13);
    press_seq('{12, 2, 14, 9});
    check("t5_issue_key_ignored", longint'(entry_mag), m_mag);
    wait_result();
    check("t5_chain", longint'(result), 26);

    // abandon in S_WAIT, late response must be ignored
    resp_mode = 2;
    press_seq('{15, 3, 10, 4, 14});
    idle(4);
    rv0 = rv_count;
    press(15);
    check("t6_busy_after_clear", longint'(busy), 0);
    idle(40);
    check("t6_late_ignored", longint'(rv_count - rv0), 0);
    resp_mode = 0;

    // reset mid-entry
    press_seq('{5, 6});
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst2_entry_mag", longint'(entry_mag), 0);
    check("rst2_result", longint'(result), 0);
    check("rst2_n1", longint'(bus.n1), 0);
    check("rst2_n2", longint'(bus.n2), 0);
    check("rst2_op_sel", longint'(bus.op_sel), 0);
    check("rst2_result_err", longint'(result_err), 0);
    rst = 1'b0;
    model_reset();
    idle(2);

    // randomized key stream against the model
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55)      k = int'($urandom_range(0, 9));
      else if (r < 70) k = 10 + int'($urandom_range(0, 3));
      else if (r < 78) k = 11;
      else if (r < 96) k = 14;
      else             k = 15;
      press(k);
      check("entry_mag", longint'(entry_mag), m_mag);
      check("entry_neg", longint'(entry_neg), longint'(m_neg));
      if (last_issued) wait_result();
    end
    idle(10);

    check("issue_queue_drained", longint'(iss_q.size()), 0);
    check("result_queue_drained", longint'(res_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
